// File: rtl/led_colour_sequencer_pkg.sv
// Shared definitions for the LED colour sequencer: FSM state encodings
// and direction codes.
package led_colour_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_colour_sequencer_rate_tick.sv
// Step-rate prescaler. In continuous mode the sequencer steps when the
// counter is zero, reloads it with rate, and counts down in between.
module led_colour_sequencer_rate_tick #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              dec,
  input  logic [RATE_W-1:0] rate,
  output logic              zero
);

  localparam logic [RATE_W-1:0] ONE = RATE_W'(1);

  logic [RATE_W-1:0] cnt;

  // Counter: clear wins over reload, reload wins over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= rate;
    end else if (dec) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_colour_sequencer.sv
// LED colour sequencer: steps a WIDTH-bit colour code through
// MIN_VAL..MAX_VAL, up or down, continuously at a programmable rate or
// one step per button press, with synchronous clear and a wrap pulse.
//
// Handshake: none. button is a level input sampled on every rising edge;
// colour and wrap are registered and valid every cycle.
module led_colour_sequencer
  import led_colour_sequencer_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 6,
  parameter int RATE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              mode,
  input  logic              dir,
  input  logic [RATE_W-1:0] rate,
  input  logic              clear,
  output logic [WIDTH-1:0]  colour,
  output logic              wrap
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Reject a range that is empty or does not fit in WIDTH bits.
  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2**WIDTH) - 1)) begin : g_bad_params
    $error("led_colour_sequencer: illegal MIN_VAL/MAX_VAL/WIDTH combination");
  end

  state_t           state;
  state_t           state_nx;
  logic             btn_q;
  logic             step;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clr;
  logic             cnt_zero;
  logic [WIDTH-1:0] colour_nx;
  logic             wrap_nx;

  led_colour_sequencer_rate_tick #(
    .RATE_W (RATE_W)
  ) u_rate_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .load (cnt_load),
    .dec  (cnt_dec),
    .rate (rate),
    .zero (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and step/prescaler control; clear suppresses any step.
  always_comb begin
    state_nx = state;
    step     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (button && !mode) begin
          // First high sample steps at once; the period starts here.
          step     = 1'b1;
          cnt_load = 1'b1;
          state_nx = RUN;
        end else if (button && mode && !btn_q) begin
          step     = 1'b1;
          state_nx = WAIT_REL;
        end
      end
      RUN: begin
        if (!button || mode) begin
          cnt_clr  = 1'b1;
          state_nx = IDLE;
        end else if (cnt_zero) begin
          step     = 1'b1;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!button) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (clear) begin
      step    = 1'b0;
      cnt_clr = 1'b1;
    end
  end

  // Candidate next colour and wrap flag for a step in the current direction.
  always_comb begin
    colour_nx = colour;
    wrap_nx   = 1'b0;
    if (dir == DIR_DN) begin
      if (colour == MIN_C) begin
        colour_nx = MAX_C;
        wrap_nx   = 1'b1;
      end else begin
        colour_nx = colour - ONE_C;
      end
    end else begin
      if (colour == MAX_C) begin
        colour_nx = MIN_C;
        wrap_nx   = 1'b1;
      end else begin
        colour_nx = colour + ONE_C;
      end
    end
  end

  // Colour and wrap registers; wrap is high only on a wrapping step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour <= MIN_C;
      wrap   <= 1'b0;
    end else if (clear) begin
      colour <= MIN_C;
      wrap   <= 1'b0;
    end else if (step) begin
      colour <= colour_nx;
      wrap   <= wrap_nx;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Button delayed one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= button;
    end
  end

endmodule

// File: tb/tb_led_colour_sequencer.sv
// Bench for led_colour_sequencer: directed scenarios plus randomized
// stimulus against a behavioural model of the sequence rules.
module tb_led_colour_sequencer;

  localparam int MIN_A = 1;
  localparam int MAX_A = 6;

  // Clock/reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       mode;
  logic       dir;
  logic [7:0] rate;
  logic       clear;
  logic [2:0] colour;
  logic       wrap;

  logic       rst2;
  logic       button2;
  logic       dir2;
  logic [3:0] colour2;
  logic       wrap2;

  always #5 clk = ~clk;

  led_colour_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .mode   (mode),
    .dir    (dir),
    .rate   (rate),
    .clear  (clear),
    .colour (colour),
    .wrap   (wrap)
  );

  led_colour_sequencer #(
    .WIDTH   (4),
    .MIN_VAL (0),
    .MAX_VAL (15),
    .RATE_W  (8)
  ) dut_wide (
    .clk    (clk),
    .rst    (rst2),
    .button (button2),
    .mode   (1'b0),
    .dir    (dir2),
    .rate   (8'd0),
    .clear  (1'b0),
    .colour (colour2),
    .wrap   (wrap2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: running = continuous stepping active, wait_cnt =
  // cycles left before the next continuous step, held = single step taken
  // and waiting for release, prev = button seen at the previous edge.
  int m_colour;
  bit m_wrap;
  bit m_running;
  bit m_held;
  int m_wait_cnt;
  bit m_prev;

  function automatic int seq_next(int c, bit down, int mn, int mx, output bit w);
    int n;
    n = mx - mn + 1;
    if (down) begin
      w = (c == mn);
      return ((c - mn + n - 1) % n) + mn;
    end else begin
      w = (c == mx);
      return ((c - mn + 1) % n) + mn;
    end
  endfunction

  task automatic model_reset();
    m_colour   = MIN_A;
    m_wrap     = 1'b0;
    m_running  = 1'b0;
    m_held     = 1'b0;
    m_wait_cnt = 0;
    m_prev     = 1'b0;
  endtask

  task automatic model_edge();
    bit do_step;
    bit w;
    do_step = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_running) begin
      if (!button || mode) begin
        m_running  = 1'b0;
        m_wait_cnt = 0;
      end else if (m_wait_cnt == 0) begin
        do_step    = 1'b1;
        m_wait_cnt = int'(rate);
      end else begin
        m_wait_cnt = m_wait_cnt - 1;
      end
    end else if (m_held) begin
      if (!button) m_held = 1'b0;
    end else begin
      if (button && !mode) begin
        do_step    = 1'b1;
        m_wait_cnt = int'(rate);
        m_running  = 1'b1;
      end else if (button && mode && !m_prev) begin
        do_step = 1'b1;
        m_held  = 1'b1;
      end
    end
    if (clear) begin
      m_colour   = MIN_A;
      m_wrap     = 1'b0;
      m_wait_cnt = 0;
    end else if (do_step) begin
      m_colour = seq_next(m_colour, dir, MIN_A, MAX_A, w);
      m_wrap   = w;
    end else begin
      m_wrap = 1'b0;
    end
    m_prev = button;
  endtask

  // Driver: one clock edge, model update, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; mode = 1'b0; dir = 1'b0; rate = 8'd0; clear = 1'b0;
    rst2 = 1'b1; button2 = 1'b0; dir2 = 1'b0;
    model_reset();
    tick();
    tick();
    n_checks++;
    if (colour !== 3'b001 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: colour=%0d wrap=%0b, required colour=1 wrap=0", colour, wrap);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (colour !== 3'd1 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: colour=%0d wrap=%0b, required colour=1 wrap=0", i, colour, wrap);
      end
    end
  endtask

  task automatic test_continuous();
    int exp_c[6] = '{2, 3, 4, 5, 6, 1};
    mode = 1'b0; dir = 1'b0; rate = 8'd0; button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (colour !== 3'(exp_c[i]) || wrap !== (i == 5) || colour !== 3'(m_colour)) begin
        n_fail++;
        $display("FAIL continuous[%0d]: colour=%0d wrap=%0b, required colour=%0d wrap=%0b",
                 i, colour, wrap, exp_c[i], (i == 5));
      end
    end
    button = 1'b0;
    tick();
    n_checks++;
    if (colour !== 3'd1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL continuous_exit: colour=%0d wrap=%0b, required colour=1 wrap=0", colour, wrap);
    end
  endtask

  task automatic test_rate();
    int exp_c[4] = '{2, 2, 2, 3};
    mode = 1'b0; dir = 1'b0; rate = 8'd2; button = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (colour !== 3'(exp_c[i]) || colour !== 3'(m_colour) || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL rate2_edge%0d: colour=%0d wrap=%0b, required colour=%0d wrap=0", i + 1, colour, wrap, exp_c[i]);
      end
    end
    tick();
    button = 1'b0;
    tick();
    button = 1'b1;
    tick();
    n_checks++;
    if (colour !== 3'd4 || colour !== 3'(m_colour)) begin
      n_fail++;
      $display("FAIL rate_reraise: colour=%0d, required 4", colour);
    end
  endtask

  task automatic test_edge_mode();
    int base;
    int expv;
    bit w;
    mode = 1'b1; button = 1'b0; rate = 8'd0;
    tick();
    base = int'(colour);
    button = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    expv = seq_next(base, 1'b0, MIN_A, MAX_A, w);
    n_checks++;
    if (colour !== 3'(expv) || colour !== 3'(m_colour)) begin
      n_fail++;
      $display("FAIL edge_held: colour=%0d, required %0d", colour, expv);
    end
    for (int p = 0; p < 2; p++) begin
      button = 1'b0;
      tick();
      button = 1'b1;
      tick();
    end
    button = 1'b0;
    tick();
    expv = seq_next(expv, 1'b0, MIN_A, MAX_A, w);
    expv = seq_next(expv, 1'b0, MIN_A, MAX_A, w);
    n_checks++;
    if (colour !== 3'(expv) || colour !== 3'(m_colour)) begin
      n_fail++;
      $display("FAIL edge_two_presses: colour=%0d, required %0d", colour, expv);
    end
  endtask

  task automatic test_down_clear();
    int exp_c[3] = '{6, 5, 4};
    mode = 1'b0; button = 1'b0; dir = 1'b1; rate = 8'd0; clear = 1'b1;
    tick();
    clear = 1'b0;
    button = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (colour !== 3'(exp_c[i]) || wrap !== (i == 0)) begin
        n_fail++;
        $display("FAIL down[%0d]: colour=%0d wrap=%0b, required colour=%0d wrap=%0b",
                 i, colour, wrap, exp_c[i], (i == 0));
      end
    end
    clear = 1'b1;
    tick();
    n_checks++;
    if (colour !== 3'd1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_run: colour=%0d wrap=%0b, required colour=1 wrap=0", colour, wrap);
    end
    clear = 1'b0;
    tick();
    n_checks++;
    if (colour !== 3'd6 || wrap !== 1'b1 || colour !== 3'(m_colour)) begin
      n_fail++;
      $display("FAIL after_clear: colour=%0d wrap=%0b, required colour=6 wrap=1", colour, wrap);
    end
    button = 1'b0; dir = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    mode = 1'b0; dir = 1'b0; rate = 8'd0; button = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (colour !== 3'd1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: colour=%0d wrap=%0b, required colour=1 wrap=0 before edge", colour, wrap);
    end
    button = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0) button = ~button;
      if ($urandom_range(15, 0) == 0) mode = ~mode;
      if ($urandom_range(7, 0) == 0) dir = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) rate = 8'($urandom_range(3, 0));
      clear = ($urandom_range(19, 0) == 0);
      tick();
      n_checks++;
      if (colour !== 3'(m_colour) || wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL random[%0d]: colour=%0d wrap=%0b, required colour=%0d wrap=%0b",
                 i, colour, wrap, m_colour, m_wrap);
      end
    end
    clear = 1'b0; button = 1'b0;
    tick();
  endtask

  task automatic test_wide_params();
    int expv;
    bit w;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    n_checks++;
    if (colour2 !== 4'd0 || wrap2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_reset: colour=%0d wrap=%0b, required colour=0 wrap=0", colour2, wrap2);
    end
    expv = 0;
    button2 = 1'b1; dir2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      expv = seq_next(expv, 1'b0, 0, 15, w);
      n_checks++;
      if (colour2 !== 4'(expv) || wrap2 !== w) begin
        n_fail++;
        $display("FAIL wide_up[%0d]: colour=%0d wrap=%0b, required colour=%0d wrap=%0b", i, colour2, wrap2, expv, w);
      end
    end
    dir2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expv = seq_next(expv, 1'b1, 0, 15, w);
      n_checks++;
      if (colour2 !== 4'(expv) || wrap2 !== w) begin
        n_fail++;
        $display("FAIL wide_down[%0d]: colour=%0d wrap=%0b, required colour=%0d wrap=%0b", i, colour2, wrap2, expv, w);
      end
    end
    button2 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_rate();
    test_edge_mode();
    test_down_clear();
    test_async_reset();
    test_random();
    test_wide_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
